// File: rtl/bus_pkg.sv
// Shared definitions for the cpu-to-slave bus fabric: status bit positions,
// read FSM states and the address-window match helper.
package bus_pkg;

  localparam int ERR_STICKY  = 31;
  localparam int ERR_TIMEOUT = 30;
  localparam int ERR_OVERRUN = 29;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } rd_state_e;

  // Windows are aligned to their size, so comparing the bits above the
  // window size is a complete match.
  function automatic logic window_hit(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [4:0]  size_log2);
    return (addr >> size_log2) == (base >> size_log2);
  endfunction

endpackage

// File: rtl/addr_decode.sv
// Combinational address decoder: one-hot slave select (lowest index wins),
// binary index, unmapped flag and the offset within the selected window.
module addr_decode
  import bus_pkg::*;
#(
  parameter int              AW        = 30,
  parameter int              N         = 4,
  parameter logic [N*AW-1:0] BASE      = '0,
  parameter logic [N*5-1:0]  SIZE_LOG2 = {N{5'd11}},
  parameter logic [AW-1:0]   ERR_ADDR  = '1,
  parameter int              IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic [AW-1:0] addr_i,
  output logic [N-1:0]  sel_o,
  output logic [IW-1:0] idx_o,
  output logic          unmapped_o,
  output logic          err_hit_o,
  output logic [AW-1:0] offset_o
);

  logic [N-1:0]  hit;
  logic [AW-1:0] base_sel;
  logic          found;

  assign err_hit_o = (addr_i == ERR_ADDR);

  always_comb begin
    hit = '0;
    for (int i = 0; i < N; i++) begin
      hit[i] = window_hit(32'(addr_i), 32'(BASE[i*AW +: AW]), SIZE_LOG2[i*5 +: 5]);
    end
  end

  // The status register address shadows any slave window that overlaps it.
  always_comb begin
    sel_o    = '0;
    idx_o    = '0;
    base_sel = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && hit[i] && !err_hit_o) begin
        sel_o[i] = 1'b1;
        idx_o    = IW'(i);
        base_sel = BASE[i*AW +: AW];
        found    = 1'b1;
      end
    end
  end

  assign unmapped_o = !err_hit_o && !found;
  assign offset_o   = addr_i - base_sel;

endmodule

// File: rtl/bus_fabric.sv
// Memory-mapped interconnect from the cpu master to N slaves with handshaked
// reads, a per-read timeout and a sticky error status register.
//
//   state   | meaning
//   IDLE    | no read outstanding; requests decoded and forwarded
//   WAIT    | read outstanding on slave idx_q; m_busy high, timeout counting
module bus_fabric
  import bus_pkg::*;
#(
  parameter int              AW        = 30,
  parameter int              N         = 4,
  parameter logic [N*AW-1:0] BASE      = '0,
  parameter logic [N*5-1:0]  SIZE_LOG2 = {N{5'd11}},
  parameter int              TIMEOUT   = 15,
  parameter logic [AW-1:0]   ERR_ADDR  = AW'(30'h3FFF_FFFF)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m_addr,
  input  logic [31:0]     m_wdata,
  input  logic            m_re,
  input  logic            m_we,
  output logic [31:0]     m_rdata,
  output logic            m_rvalid,
  output logic            m_busy,
  output logic            m_err,
  output logic [AW-1:0]   s_addr,
  output logic [31:0]     s_wdata,
  output logic [N-1:0]    s_re,
  output logic [N-1:0]    s_we,
  input  logic [N*32-1:0] s_rdata,
  input  logic [N-1:0]    s_rvalid
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  rd_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          sticky_q, sticky_d;
  logic          timeout_q, timeout_d;
  logic          overrun_q, overrun_d;
  logic [AW-1:0] eaddr_q, eaddr_d;

  logic [N-1:0]  dec_sel;
  logic [IW-1:0] dec_idx;
  logic          dec_unmapped;
  logic          dec_err;
  logic [AW-1:0] dec_offset;

  logic          idle;
  logic [31:0]   status_word;
  logic          rv_sel;
  logic [31:0]   rd_sel;
  logic          fail;
  logic [AW-1:0] fail_addr;

  addr_decode #(
    .AW        (AW),
    .N         (N),
    .BASE      (BASE),
    .SIZE_LOG2 (SIZE_LOG2),
    .ERR_ADDR  (ERR_ADDR),
    .IW        (IW)
  ) u_decode (
    .addr_i     (m_addr),
    .sel_o      (dec_sel),
    .idx_o      (dec_idx),
    .unmapped_o (dec_unmapped),
    .err_hit_o  (dec_err),
    .offset_o   (dec_offset)
  );

  assign idle     = (state_q == ST_IDLE);
  assign s_re     = (m_re && idle) ? dec_sel : '0;
  assign s_we     = (m_we && idle) ? dec_sel : '0;
  assign s_addr   = dec_offset;
  assign s_wdata  = m_wdata;
  assign m_busy   = !idle;
  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;
  assign m_err    = sticky_q;

  // With AW=30 the top captured address bit shares bit 29 with overrun.
  assign status_word = {sticky_q, timeout_q, overrun_q, 29'b0} | 32'(eaddr_q);

  always_comb begin
    rv_sel = 1'b0;
    rd_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == idx_q) begin
        rv_sel = s_rvalid[i];
        rd_sel = s_rdata[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    raddr_d   = raddr_q;
    cnt_d     = cnt_q;
    rvalid_d  = 1'b0;
    rdata_d   = '0;
    sticky_d  = sticky_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    eaddr_d   = eaddr_q;
    fail      = 1'b0;
    fail_addr = '0;

    case (state_q)
      ST_IDLE: begin
        if (m_we && dec_err) begin
          sticky_d  = 1'b0;
          timeout_d = 1'b0;
          overrun_d = 1'b0;
          eaddr_d   = '0;
        end
        if (m_re) begin
          if (dec_err) begin
            rvalid_d = 1'b1;
            rdata_d  = status_word;
          end else if (dec_unmapped) begin
            rvalid_d  = 1'b1;
            fail      = 1'b1;
            fail_addr = m_addr;
          end else begin
            state_d = ST_WAIT;
            idx_d   = dec_idx;
            raddr_d = m_addr;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        if (m_re || m_we) overrun_d = 1'b1;
        if (rv_sel) begin
          rvalid_d = 1'b1;
          rdata_d  = rd_sel;
          state_d  = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          rvalid_d  = 1'b1;
          timeout_d = 1'b1;
          fail      = 1'b1;
          fail_addr = raddr_q;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only the first failure since the last clear records its address.
    if (fail) begin
      if (!sticky_d) eaddr_d = fail_addr;
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      raddr_q   <= '0;
      cnt_q     <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      sticky_q  <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      eaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      raddr_q   <= raddr_d;
      cnt_q     <= cnt_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      sticky_q  <= sticky_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
      eaddr_q   <= eaddr_d;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric: three slaves at 0x0000/2K, 0x4000/2, 0x4100/1
// with hand-computed responses, timeout, error status and reset behaviour.
module tb_bus_fabric;

  localparam int            AW      = 30;
  localparam int            N       = 3;
  localparam int            TIMEOUT = 15;
  localparam logic [AW-1:0] ERR_A   = 30'h3FFF_FFFF;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   m_addr;
  logic [31:0]     m_wdata;
  logic            m_re;
  logic            m_we;
  logic [31:0]     m_rdata;
  logic            m_rvalid;
  logic            m_busy;
  logic            m_err;
  logic [AW-1:0]   s_addr;
  logic [31:0]     s_wdata;
  logic [N-1:0]    s_re;
  logic [N-1:0]    s_we;
  logic [N*32-1:0] s_rdata;
  logic [N-1:0]    s_rvalid;

  int n_checks = 0;
  int n_fail   = 0;
  int k;
  int early;

  bus_fabric #(
    .AW        (AW),
    .N         (N),
    .BASE      ({30'h4100, 30'h4000, 30'h0000}),
    .SIZE_LOG2 ({5'd0, 5'd1, 5'd11}),
    .TIMEOUT   (TIMEOUT),
    .ERR_ADDR  (ERR_A)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_re     (m_re),
    .m_we     (m_we),
    .m_rdata  (m_rdata),
    .m_rvalid (m_rvalid),
    .m_busy   (m_busy),
    .m_err    (m_err),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_re     (s_re),
    .s_we     (s_we),
    .s_rdata  (s_rdata),
    .s_rvalid (s_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_status(input string tag, input logic [31:0] exp);
    m_addr = ERR_A;
    m_re   = 1'b1;
    #1;
    chk({tag, "_sre"}, 64'(s_re), 64'h0);
    step();
    m_re = 1'b0;
    chk({tag, "_rvalid"}, 64'(m_rvalid), 64'h1);
    chk({tag, "_word"}, 64'(m_rdata), 64'(exp));
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [31:0] data);
    m_addr  = addr;
    m_wdata = data;
    m_we    = 1'b1;
    step();
    m_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    m_addr   = '0;
    m_wdata  = '0;
    m_re     = 1'b0;
    m_we     = 1'b0;
    s_rdata  = '0;
    s_rvalid = '0;
    repeat (3) step();
    chk("rst_rvalid", 64'(m_rvalid), 64'h0);
    chk("rst_busy", 64'(m_busy), 64'h0);
    chk("rst_rdata", 64'(m_rdata), 64'h0);
    chk("rst_err", 64'(m_err), 64'h0);
    reset = 1'b0;
    step();
    rd_status("rst_status", 32'h0);

    // posted write to slave 1
    m_addr  = 30'h4000;
    m_wdata = 32'h41;
    m_we    = 1'b1;
    #1;
    chk("wr_swe", 64'(s_we), 64'h2);
    chk("wr_saddr", 64'(s_addr), 64'h0);
    chk("wr_swdata", 64'(s_wdata), 64'h41);
    chk("wr_busy", 64'(m_busy), 64'h0);
    step();
    m_we = 1'b0;
    #1;
    chk("wr_swe_off", 64'(s_we), 64'h0);
    chk("wr_busy_after", 64'(m_busy), 64'h0);

    // minimum-latency read from slave 0
    m_addr = 30'h0005;
    m_re   = 1'b1;
    #1;
    chk("rd0_sre", 64'(s_re), 64'h1);
    chk("rd0_saddr", 64'(s_addr), 64'h5);
    chk("rd0_busy_t", 64'(m_busy), 64'h0);
    step();
    m_re = 1'b0;
    chk("rd0_busy_t1", 64'(m_busy), 64'h1);
    chk("rd0_rvalid_t1", 64'(m_rvalid), 64'h0);
    s_rdata[31:0] = 32'hCAFE_F00D;
    s_rvalid      = 3'b001;
    step();
    s_rvalid = '0;
    chk("rd0_rvalid_t2", 64'(m_rvalid), 64'h1);
    chk("rd0_data", 64'(m_rdata), 64'hCAFE_F00D);
    chk("rd0_busy_t2", 64'(m_busy), 64'h0);
    step();
    chk("rd0_rvalid_t3", 64'(m_rvalid), 64'h0);

    // slave 1 never answers
    m_addr = 30'h4001;
    m_re   = 1'b1;
    #1;
    chk("to_sre", 64'(s_re), 64'h2);
    chk("to_saddr", 64'(s_addr), 64'h1);
    step();
    m_re = 1'b0;
    k = 1;
    while (!m_rvalid && k < 40) begin
      step();
      k++;
    end
    chk("to_latency", 64'(k), 64'(TIMEOUT + 2));
    chk("to_data", 64'(m_rdata), 64'h0);
    chk("to_err", 64'(m_err), 64'h1);
    chk("to_busy", 64'(m_busy), 64'h0);
    rd_status("to_status", 32'hC000_4001);

    // unmapped read, then a normal read to slave 2
    wr(ERR_A, 32'h0);
    rd_status("clr_status", 32'h0);
    chk("clr_err", 64'(m_err), 64'h0);
    m_addr = 30'h2000;
    m_re   = 1'b1;
    #1;
    chk("unm_sre", 64'(s_re), 64'h0);
    step();
    m_re = 1'b0;
    chk("unm_rvalid", 64'(m_rvalid), 64'h1);
    chk("unm_data", 64'(m_rdata), 64'h0);
    chk("unm_busy", 64'(m_busy), 64'h0);
    chk("unm_err", 64'(m_err), 64'h1);
    m_addr = 30'h4100;
    m_re   = 1'b1;
    #1;
    chk("rd2_sre", 64'(s_re), 64'h4);
    chk("rd2_saddr", 64'(s_addr), 64'h0);
    step();
    m_re           = 1'b0;
    s_rdata[95:64] = 32'h1234_5678;
    s_rvalid       = 3'b100;
    step();
    s_rvalid = '0;
    chk("rd2_rvalid", 64'(m_rvalid), 64'h1);
    chk("rd2_data", 64'(m_rdata), 64'h1234_5678);
    rd_status("unm_status", 32'h8000_2000);

    // requests and a foreign response while waiting on slave 2
    wr(ERR_A, 32'h0);
    m_addr = 30'h4100;
    m_re   = 1'b1;
    step();
    chk("ovr_busy", 64'(m_busy), 64'h1);
    m_addr        = 30'h0005;
    m_re          = 1'b1;
    m_we          = 1'b1;
    s_rdata[31:0] = 32'hDEAD_BEEF;
    s_rvalid      = 3'b001;
    #1;
    chk("ovr_sre", 64'(s_re), 64'h0);
    chk("ovr_swe", 64'(s_we), 64'h0);
    step();
    m_re     = 1'b0;
    m_we     = 1'b0;
    s_rvalid = '0;
    chk("ovr_no_rvalid", 64'(m_rvalid), 64'h0);
    chk("ovr_still_busy", 64'(m_busy), 64'h1);
    s_rdata[95:64] = 32'h55AA_55AA;
    s_rvalid       = 3'b100;
    step();
    s_rvalid = '0;
    chk("ovr_rvalid", 64'(m_rvalid), 64'h1);
    chk("ovr_data", 64'(m_rdata), 64'h55AA_55AA);
    rd_status("ovr_status", 32'h2000_0000);
    chk("ovr_err", 64'(m_err), 64'h0);

    // response arrives in the cycle the counter reaches TIMEOUT
    wr(ERR_A, 32'h0);
    m_addr = 30'h4001;
    m_re   = 1'b1;
    step();
    m_re  = 1'b0;
    early = 0;
    repeat (TIMEOUT) begin
      if (m_rvalid) early++;
      step();
    end
    chk("edge_no_early", 64'(early), 64'h0);
    s_rdata[63:32] = 32'h1357_9BDF;
    s_rvalid       = 3'b010;
    step();
    s_rvalid = '0;
    chk("edge_rvalid", 64'(m_rvalid), 64'h1);
    chk("edge_data", 64'(m_rdata), 64'h1357_9BDF);
    rd_status("edge_status", 32'h0);

    // reset abandons an outstanding read and clears status
    m_addr = 30'h2000;
    m_re   = 1'b1;
    step();
    m_re = 1'b0;
    chk("pre_rst_err", 64'(m_err), 64'h1);
    m_addr = 30'h4000;
    m_re   = 1'b1;
    step();
    m_re = 1'b0;
    chk("rstw_busy", 64'(m_busy), 64'h1);
    reset = 1'b1;
    step();
    reset          = 1'b0;
    s_rdata[63:32] = 32'h0000_0099;
    s_rvalid       = 3'b010;
    step();
    s_rvalid = '0;
    chk("rstw_rvalid", 64'(m_rvalid), 64'h0);
    chk("rstw_busy_after", 64'(m_busy), 64'h0);
    chk("rstw_rdata", 64'(m_rdata), 64'h0);
    chk("rstw_err", 64'(m_err), 64'h0);
    chk("rstw_sre", 64'(s_re), 64'h0);
    chk("rstw_swe", 64'(s_we), 64'h0);
    step();
    chk("rstw_rvalid_late", 64'(m_rvalid), 64'h0);
    wr(ERR_A, 32'h0);
    rd_status("post_rst_status", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Parametrised memory-mapped interconnect between the single cpu master and N slave channels (ram, uart, gpio, ...). Replaces the hard-wired address compares and the fixed 2-way registered read mux.
- Per-slave base and size are set by parameters. Read responses are handshaked with per-slave variable latency and a timeout.
- Unmapped or timed-out accesses are captured in an internal error status register.

Parameters:
- AW, 30, word-address width (byte address bits [1:0] implicit)
- N, 4, number of slave channels (1..8)
- BASE, {N{30'h0}}, packed N*AW vector; slave i base word address at [i*AW +: AW]
- SIZE_LOG2, {N{5'd11}}, packed N*5 vector; slave i window = 2**SIZE_LOG2[i] words, base aligned to the window
- TIMEOUT, 15, max cycles to wait for s_rvalid; counter width = clog2(TIMEOUT+1)
- ERR_ADDR, 30'h3FFF_FFFF, word address of the error status register

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_addr  in  AW  master word address
- m_wdata  in  32  master write data
- m_re  in  1  read request, single-cycle pulse
- m_we  in  1  write request, single-cycle pulse
- m_rdata  out  32  read data, valid only while m_rvalid=1
- m_rvalid  out  1  one-cycle read-response strobe
- m_busy  out  1  read outstanding; master must not issue requests
- m_err  out  1  sticky error flag (status bit 31)
- s_addr  out  AW  m_addr minus the selected base, passed combinationally
- s_wdata  out  32  m_wdata, passed combinationally
- s_re  out  N  per-slave read strobe, combinational
- s_we  out  N  per-slave write strobe, combinational
- s_rdata  in  N*32  packed slave read data
- s_rvalid  in  N  per-slave read-response strobe, one cycle

Behaviour:
- Decode (combinational):
  - hit[i] = (m_addr >> SIZE_LOG2[i]) == (BASE[i] >> SIZE_LOG2[i]).
  - Lowest hitting index wins, giving a one-hot select.
  - ERR_ADDR takes precedence over all slave windows.
- Writes are posted:
  - s_we[sel] = m_we in the same cycle; no response.
  - m_we while busy is ignored and sets the status overrun bit.
  - A write to ERR_ADDR clears the whole status register.
- Read FSM has two states, IDLE and WAIT.
  - IDLE, m_re to a mapped slave: assert s_re[sel], latch the index into idx_q, clear the timeout counter, go to WAIT.
  - IDLE, m_re to ERR_ADDR or an unmapped address: no s_re. Next cycle m_rvalid=1.
    - ERR_ADDR read returns the status word.
    - Unmapped read returns 0, sets the sticky bit and captures the address.
    - FSM stays in IDLE.
  - WAIT: m_busy=1.
    - s_rvalid[idx_q]=1: register s_rdata[idx_q] into m_rdata. m_rvalid=1 the next cycle; return to IDLE.
    - Counter reaches TIMEOUT without s_rvalid[idx_q]: m_rvalid=1 next cycle with m_rdata=0; set sticky and timeout bits; capture the address; return to IDLE.
    - s_rvalid[idx_q] in the same cycle the counter reaches TIMEOUT: the response wins and no error is recorded.
    - s_rvalid from any slave other than idx_q is ignored.
    - m_re or m_we while in WAIT is ignored and sets the overrun bit.
- Minimum read latency: m_re at cycle t, slave responds at t+1, m_rvalid at t+2. A zero-wait slave ties s_rvalid to its registered re.
- Status word layout:
  - [31] sticky
  - [30] timeout
  - [29] overrun
  - [AW-1:0] first failing word address; later errors do not overwrite it until cleared
  - All other bits read as 0.
- m_err = status[31].
- Reset values: FSM=IDLE, m_rvalid=0, m_busy=0, m_rdata=0, status=0, counter=0.
- Reset mid-WAIT abandons the read: no m_rvalid is produced, and a late s_rvalid is ignored.

Decomposition:
- Package bus_pkg:
  - status bit index constants ERR_STICKY=31, ERR_TIMEOUT=30, ERR_OVERRUN=29
  - FSM state enum
  - function window_hit(addr, base, size_log2)
- Sub-module addr_decode: purely combinational, produces the one-hot select, index, an unmapped flag and the offset address. It is instantiated once; the FSM, status register and response mux stay in bus_fabric.

Test Plan:
- Setup: N=3; BASE = {0x0000, 0x4000, 0x4100}; SIZE_LOG2 = {11, 1, 0}.
- Write m_addr=0x4000, wdata=0x41 -> s_we=3'b010 for one cycle, s_addr=0, s_wdata=0x41; m_busy stays 0.
- Read 0x0005, slave 0 returns 0xCAFEF00D one cycle later -> m_rvalid at t+2 with m_rdata=0xCAFEF00D; m_busy high for exactly one cycle.
- Read 0x4001, slave 1 withholds s_rvalid -> m_rvalid after TIMEOUT+1 cycles with m_rdata=0; ERR_ADDR read returns 0xC000_4001; m_err=1.
- Read 0x2000 (unmapped), then read 0x4100 -> first returns 0 and captures 0x2000; second completes normally; captured address stays 0x2000.
- While WAIT on slave 2, pulse m_re and m_we, and raise s_rvalid[0] -> no new s_re or s_we; overrun bit set; slave-0 data is not returned.
- Assert reset during WAIT, then drive s_rvalid[idx] -> no m_rvalid; all outputs 0. A write to ERR_ADDR afterwards leaves status=0.
